// File: rtl/alu_pipe_stream.sv
// Elastic two-stage ALU: stage 1 registers operands over a valid/ready handshake,
// stage 2 registers the result and flags; includes an op counter and sticky flags.
module alu_pipe_stream #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic             negative,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             illegal_op,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] op_count,
  output logic             sticky_overflow,
  output logic             sticky_carry
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_SRA = 4'd8
  } alu_op_e;

  // W always fits in W bits because W >= 2.
  localparam logic [W-1:0] SH_LIM = W'(W);

  // Stage 1: captured operands.
  logic         r_s1_valid;
  logic [W-1:0] r_s1_a;
  logic [W-1:0] r_s1_b;
  logic [3:0]   r_s1_op;

  // Stage 2: registered result and flags.
  logic         r_s2_valid;
  logic [W-1:0] r_result;
  logic         r_negative;
  logic         r_zero;
  logic         r_carry;
  logic         r_overflow;
  logic         r_illegal;

  logic [CNT_W-1:0] r_op_count;
  logic             r_sticky_ovf;
  logic             r_sticky_carry;

  logic w_s2_adv;
  logic w_s1_adv;
  logic w_in_xfer;
  logic w_out_xfer;

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_adv;
  assign in_ready   = !r_s1_valid || w_s1_adv;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_s2_valid && out_ready;

  // NOTE: datapath registers are reset too, so result and flags read 0 after reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else begin
      if (w_in_xfer) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= a;
        r_s1_b     <= b;
        r_s1_op    <= alu_control;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic         w_sh_big;
  logic [W-1:0] w_res;
  logic         w_carry;
  logic         w_ovf;
  logic         w_ill;

  assign w_sum    = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff   = {1'b0, r_s1_a} - {1'b0, r_s1_b};
  assign w_sh_big = (r_s1_b >= SH_LIM);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    case (r_s1_op)
      OP_ADD: begin
        w_res   = w_sum[W-1:0];
        w_carry = w_sum[W];
        w_ovf   = (r_s1_a[W-1] == r_s1_b[W-1]) && (w_sum[W-1] != r_s1_a[W-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[W-1:0];
        w_carry = !w_diff[W];
        w_ovf   = (r_s1_a[W-1] != r_s1_b[W-1]) && (w_diff[W-1] != r_s1_a[W-1]);
      end
      OP_AND: w_res = r_s1_a & r_s1_b;
      OP_OR:  w_res = r_s1_a | r_s1_b;
      OP_XOR: w_res = r_s1_a ^ r_s1_b;
      OP_NOT: w_res = ~r_s1_a;
      OP_SHL: w_res = w_sh_big ? '0 : (r_s1_a << r_s1_b);
      OP_SHR: w_res = w_sh_big ? '0 : (r_s1_a >> r_s1_b);
      OP_SRA: w_res = w_sh_big ? {W{r_s1_a[W-1]}} : $unsigned($signed(r_s1_a) >>> r_s1_b);
      default: w_ill = 1'b1;
    endcase
  end

  // Stage 2 only loads when it advances, which holds data stable under backpressure.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_negative <= 1'b0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result   <= w_res;
        r_negative <= w_res[W-1];
        r_zero     <= (w_res == '0);
        r_carry    <= w_carry;
        r_overflow <= w_ovf;
        r_illegal  <= w_ill;
      end
    end
  end

  // clear_stats wins over a coincident output transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op_count     <= '0;
      r_sticky_ovf   <= 1'b0;
      r_sticky_carry <= 1'b0;
    end else if (clear_stats) begin
      r_op_count     <= '0;
      r_sticky_ovf   <= 1'b0;
      r_sticky_carry <= 1'b0;
    end else if (w_out_xfer) begin
      r_op_count     <= r_op_count + 1'b1;
      r_sticky_ovf   <= r_sticky_ovf | r_overflow;
      r_sticky_carry <= r_sticky_carry | r_carry;
    end
  end

  assign out_valid       = r_s2_valid;
  assign result          = r_result;
  assign negative        = r_negative;
  assign zero            = r_zero;
  assign carry_out       = r_carry;
  assign overflow        = r_overflow;
  assign illegal_op      = r_illegal;
  assign op_count        = r_op_count;
  assign sticky_overflow = r_sticky_ovf;
  assign sticky_carry    = r_sticky_carry;

endmodule

// File: tb/tb_alu_pipe_stream.sv
// Directed bench for alu_pipe_stream (W=8): ops, flags, backpressure, reset and stats.
module tb_alu_pipe_stream;

  localparam int W     = 8;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [3:0]       alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic             negative;
  logic             zero;
  logic             carry_out;
  logic             overflow;
  logic             illegal_op;
  logic             clear_stats;
  logic [CNT_W-1:0] op_count;
  logic             sticky_overflow;
  logic             sticky_carry;

  int n_pass  = 0;
  int n_total = 0;
  int exp_count = 0;

  always #5 clock = ~clock;

  alu_pipe_stream #(.W(W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .negative(negative), .zero(zero),
    .carry_out(carry_out), .overflow(overflow), .illegal_op(illegal_op),
    .clear_stats(clear_stats), .op_count(op_count),
    .sticky_overflow(sticky_overflow), .sticky_carry(sticky_carry)
  );

  // Vector layout: {result[7:0], negative, zero, carry_out, overflow, illegal_op}
  function automatic logic [12:0] vec();
    return {result, negative, zero, carry_out, overflow, illegal_op};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_b, input logic [3:0] op,
                        input logic [12:0] exp_vec, input string name);
    out_ready   = 1'b1;
    a           = ta;
    b           = tb_b;
    alu_control = op;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_total++;
    if (out_valid !== 1'b1 || vec() !== exp_vec)
      $display("FAIL %s: got valid=%b vec=%h, expected valid=1 vec=%h", name, out_valid, vec(), exp_vec);
    else n_pass++;
    tick();
    exp_count++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; alu_control = '0;
    out_ready = 1'b0; clear_stats = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || vec() !== 13'h0)
      $display("FAIL reset_outputs: got valid=%b ready=%b vec=%h, expected 0 1 0000", out_valid, in_ready, vec());
    else n_pass++;
    n_total++;
    if (op_count !== 16'd0 || sticky_overflow !== 1'b0 || sticky_carry !== 1'b0)
      $display("FAIL reset_stats: got cnt=%0d so=%b sc=%b, expected 0 0 0", op_count, sticky_overflow, sticky_carry);
    else n_pass++;
  endtask

  task automatic test_add_overflow();
    out_ready = 1'b1; a = 8'h7F; b = 8'h01; alu_control = 4'b0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL add_latency_early: got valid=%b expected 0", out_valid);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b1 || vec() !== {8'h80, 5'b10010})
      $display("FAIL add_7f_01: got valid=%b vec=%h, expected valid=1 vec=%h", out_valid, vec(), {8'h80, 5'b10010});
    else n_pass++;
    tick();
    exp_count++;
    n_total++;
    if (out_valid !== 1'b0 || op_count !== 16'd1 || sticky_overflow !== 1'b1 || sticky_carry !== 1'b0)
      $display("FAIL add_stats: got valid=%b cnt=%0d so=%b sc=%b, expected 0 1 1 0",
               out_valid, op_count, sticky_overflow, sticky_carry);
    else n_pass++;
  endtask

  task automatic test_arith();
    run_op(8'h05, 8'h05, 4'b0001, {8'h00, 5'b01100}, "sub_05_05");
    run_op(8'h00, 8'h01, 4'b0001, {8'hFF, 5'b10000}, "sub_00_01");
    run_op(8'h80, 8'h01, 4'b0001, {8'h7F, 5'b00110}, "sub_80_01_ovf");
    run_op(8'hFF, 8'h01, 4'b0000, {8'h00, 5'b01100}, "add_ff_01_carry");
    n_total++;
    if (op_count !== exp_count[CNT_W-1:0] || sticky_carry !== 1'b1 || sticky_overflow !== 1'b1)
      $display("FAIL arith_stats: got cnt=%0d sc=%b so=%b, expected %0d 1 1", op_count, sticky_carry, sticky_overflow, exp_count);
    else n_pass++;
  endtask

  task automatic test_logic();
    run_op(8'hC3, 8'h5A, 4'b0010, {8'h42, 5'b00000}, "and");
    run_op(8'hC3, 8'h5A, 4'b0011, {8'hDB, 5'b10000}, "or");
    run_op(8'hC3, 8'h5A, 4'b0100, {8'h99, 5'b10000}, "xor");
    run_op(8'hC3, 8'h5A, 4'b0101, {8'h3C, 5'b00000}, "not");
  endtask

  task automatic test_shift();
    run_op(8'h80, 8'h03, 4'b1000, {8'hF0, 5'b10000}, "sra_80_3");
    run_op(8'h80, 8'h09, 4'b1000, {8'hFF, 5'b10000}, "sra_80_9");
    run_op(8'h40, 8'hFF, 4'b1000, {8'h00, 5'b01000}, "sra_40_255");
    run_op(8'h01, 8'h08, 4'b0110, {8'h00, 5'b01000}, "shl_01_8");
    run_op(8'h01, 8'h07, 4'b0110, {8'h80, 5'b10000}, "shl_01_7");
    run_op(8'h80, 8'h07, 4'b0111, {8'h01, 5'b00000}, "shr_80_7");
    run_op(8'h80, 8'h08, 4'b0111, {8'h00, 5'b01000}, "shr_80_8");
  endtask

  task automatic test_illegal();
    run_op(8'hFF, 8'hFF, 4'b1111, {8'h00, 5'b01001}, "illegal_1111");
    run_op(8'h7F, 8'h01, 4'b1001, {8'h00, 5'b01001}, "illegal_1001");
    n_total++;
    if (op_count !== exp_count[CNT_W-1:0])
      $display("FAIL count_after_ops: got %0d expected %0d", op_count, exp_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_res [3];
    exp_res[0] = 8'h03; exp_res[1] = 8'h30; exp_res[2] = 8'h45;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    n_total++;
    if (op_count !== 16'd0) $display("FAIL b2b_clear: got cnt=%0d expected 0", op_count);
    else n_pass++;
    out_ready = 1'b0; alu_control = 4'b0000;
    a = 8'h01; b = 8'h02; in_valid = 1'b1;
    tick();
    a = 8'h10; b = 8'h20;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready_second: got %b expected 1", in_ready);
    else n_pass++;
    tick();
    a = 8'h40; b = 8'h05;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== exp_res[0])
        $display("FAIL b2b_hold_%0d: got ready=%b valid=%b res=%h, expected 0 1 %h",
                 i, in_ready, out_valid, result, exp_res[0]);
      else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready_release: got %b expected 1", in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      n_total++;
      if (out_valid !== 1'b1 || result !== exp_res[i])
        $display("FAIL b2b_order_%0d: got valid=%b res=%h, expected 1 %h", i, out_valid, result, exp_res[i]);
      else n_pass++;
      tick();
    end
    n_total++;
    if (out_valid !== 1'b0 || op_count !== 16'd3)
      $display("FAIL b2b_drain: got valid=%b cnt=%0d, expected 0 3", out_valid, op_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; alu_control = 4'b0000;
    a = 8'h11; b = 8'h22; in_valid = 1'b1;
    tick();
    a = 8'h01; b = 8'h01;
    tick();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || op_count !== 16'd0 || result !== 8'h00)
      $display("FAIL reset_mid_immediate: got valid=%b cnt=%0d res=%h, expected 0 0 00", out_valid, op_count, result);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL reset_mid_stale_%0d: got valid=%b ready=%b, expected 0 1", i, out_valid, in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_clear();
    run_op(8'h80, 8'h01, 4'b0001, {8'h7F, 5'b00110}, "clear_pre_sub");
    n_total++;
    if (op_count !== 16'd1 || sticky_overflow !== 1'b1 || sticky_carry !== 1'b1)
      $display("FAIL clear_pre_stats: got cnt=%0d so=%b sc=%b, expected 1 1 1", op_count, sticky_overflow, sticky_carry);
    else n_pass++;
    out_ready = 1'b0; a = 8'h7F; b = 8'h01; alu_control = 4'b0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1; clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || op_count !== 16'd0 || sticky_overflow !== 1'b0 || sticky_carry !== 1'b0)
      $display("FAIL clear_with_xfer: got valid=%b cnt=%0d so=%b sc=%b, expected 0 0 0 0",
               out_valid, op_count, sticky_overflow, sticky_carry);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_arith();
    test_logic();
    test_shift();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_clear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/alu_pipe_stream.md
Name: alu_pipe_stream

Overview:
- Parametrised, elastic, two-stage registered ALU. Successor to the single-bit-operand clocked ALU test wrapper.
- Operands and control are accepted over a valid/ready handshake and registered in stage 1. The operation is computed and registered with flags in stage 2.
- Results leave over a valid/ready handshake with full backpressure. Includes completed-op counter and sticky status flags for board-level bring-up and test.

Parameters:
- W, 8, operand/result width in bits (W >= 2).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clock  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  stage 1 can accept this cycle.
- a  input  W  operand A.
- b  input  W  operand B (shift amount for shifts).
- alu_control  input  4  operation select.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer takes result this cycle.
- result  output  W  operation result.
- negative  output  1  result[W-1].
- zero  output  1  result == 0.
- carry_out  output  1  carry (add) / no-borrow (sub).
- overflow  output  1  signed overflow (add/sub).
- illegal_op  output  1  alu_control not a defined op.
- clear_stats  input  1  synchronous clear of op_count and sticky flags.
- op_count  output  CNT_W  number of completed output transfers, wraps.
- sticky_overflow  output  1  set on any delivered result with overflow=1.
- sticky_carry  output  1  set on any delivered result with carry_out=1.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Both stage valids = 0; out_valid=0.
  - result=0, all flags 0; illegal_op=0.
  - op_count=0, sticky_overflow=0, sticky_carry=0.
  - in_ready=1 from the first cycle after release.
  - Reset mid-operation discards all in-flight data.
- Transfers:
  - Input transfer: in_valid && in_ready on a rising edge.
  - Output transfer: out_valid && out_ready on a rising edge.
  - Operands are stable only during the transfer cycle; stage 1 captures a, b and alu_control.
- Pipeline advance:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances into s2 when s1_valid && s2 advances.
  - in_ready = !s1_valid || (s1 advances into s2).
  - Full throughput: one op per cycle when out_ready=1.
  - Latency: out_valid rises 2 edges after the input transfer edge.
  - Results are delivered strictly in order; none are dropped or duplicated.
  - While out_valid=1 && out_ready=0, result and all flags are held stable.
- Operations (stage 1 -> stage 2 logic):
  - 0000 add a+b.
  - 0001 sub a-b.
  - 0010 and.
  - 0011 or.
  - 0100 xor.
  - 0101 not a.
  - 0110 shl a by b.
  - 0111 shr logical a by b.
  - 1000 sra a by b.
  - 1001..1111 illegal: result=0, illegal_op=1.
- Shift amount: the full unsigned b. If b >= W: shl/shr give 0, sra gives all bits = a[W-1].
- Flags:
  - negative = result[W-1]; zero = (result==0), for all ops including illegal.
  - add: carry_out = bit W of the (W+1)-bit sum; overflow = a,b same sign and result sign differs.
  - sub: carry_out = 1 iff a >= b unsigned; overflow = a,b differ in sign and result sign != a sign.
  - All other ops: carry_out=0, overflow=0.
- Statistics:
  - Updated only on an output transfer: op_count+1 (wraps at 2^CNT_W).
  - On the same output transfer, sticky_overflow |= overflow and sticky_carry |= carry_out.
  - clear_stats=1 takes priority: op_count, sticky_overflow and sticky_carry go to 0, and an output transfer in that same cycle is not counted.
  - clear_stats does not affect the pipeline.

Test Plan:
- W=8. Stimulus add 0x7F+0x01 with out_ready=1 -> 2 edges later: result=0x80, negative=1, zero=0, carry_out=0, overflow=1, op_count=1, sticky_overflow=1.
- Sub 0x05-0x05 -> result=0x00, zero=1, carry_out=1, overflow=0. Then sub 0x00-0x01 -> result=0xFF, carry_out=0, negative=1.
- sra a=0x80 b=3 -> 0xF0. sra a=0x80 b=9 -> 0xFF. shl a=0x01 b=8 -> 0x00, zero=1. shr a=0x80 b=7 -> 0x01.
- Backpressure: out_ready=0, send 3 back-to-back adds -> in_ready=0 after 2 accepted. out_valid result is held stable 5 cycles. Raise out_ready -> all 3 results in order on consecutive cycles, op_count=3.
- alu_control=1111 -> result=0, illegal_op=1, zero=1, carry_out=0, overflow=0.
- Reset mid-operation: assert reset_n=0 between edges with 2 ops in flight -> out_valid=0 and op_count=0 immediately. No stale result emerges after release.
- Clear: clear_stats=1 in the same cycle as an output transfer with overflow=1 -> op_count=0, sticky_overflow=0 next cycle.
